// File: rtl/multitap_delay.sv
// Multi-tap delay/echo engine: circular sample RAM with NTAPS programmable delayed
// reads through one synchronous read port, per-tap gains and a saturated mix.
module multitap_delay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int NTAPS   = 4,
  parameter int G_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [D_WIDTH-1:0]         sample_in,
  input  logic [NTAPS*A_WIDTH-1:0]   delay,
  input  logic [NTAPS*G_WIDTH-1:0]   gain,
  output logic [D_WIDTH-1:0]         mix_out,
  output logic                       out_valid,
  output logic                       overrun
);

  localparam int LOG_N = (NTAPS > 1) ? $clog2(NTAPS) : 0;
  localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int ACC_W = D_WIDTH + G_WIDTH + LOG_N;
  localparam int DEPTH = 1 << A_WIDTH;

  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;
  localparam logic [IDX_W-1:0]   LAST_TAP = IDX_W'(NTAPS - 1);
  localparam logic [ACC_W-1:0]   MIX_MAX  = ACC_W'((1 << D_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           tap_idx_q, tap_idx_d;
  logic [A_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0]         fill_q, fill_d;
  logic [NTAPS*A_WIDTH-1:0]   delay_q, delay_d;
  logic [NTAPS*G_WIDTH-1:0]   gain_q, gain_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [G_WIDTH-1:0]         rd_gain_q, rd_gain_d;
  logic                       rd_pend_q, rd_pend_d;
  logic [D_WIDTH-1:0]         mix_out_q, mix_out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;

  logic [D_WIDTH-1:0]         mem [DEPTH];
  logic [D_WIDTH-1:0]         ram_rd_q;

  logic                       accept;
  logic [A_WIDTH-1:0]         tap_delay;
  logic [G_WIDTH-1:0]         tap_gain;
  logic [A_WIDTH-1:0]         rd_addr;
  logic [ACC_W-1:0]           acc_sum;
  logic [ACC_W-1:0]           mix_full;
  logic [D_WIDTH-1:0]         mix_sat;

  assign in_ready  = en && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign mix_out   = mix_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  // Latched tap parameters for the tap currently being issued.
  assign tap_delay = delay_q[int'(tap_idx_q) * A_WIDTH +: A_WIDTH];
  assign tap_gain  = gain_q[int'(tap_idx_q) * G_WIDTH +: G_WIDTH];
  assign rd_addr   = wr_ptr_q - tap_delay;

  // RAM data returned this cycle belongs to the tap issued last cycle; a masked
  // tap carries gain 0 so stale RAM contents never reach the mix.
  assign acc_sum  = rd_pend_q ? acc_q + ACC_W'(ram_rd_q) * ACC_W'(rd_gain_q) : acc_q;
  assign mix_full = acc_sum >> G_WIDTH;
  assign mix_sat  = (mix_full > MIX_MAX) ? '1 : D_WIDTH'(mix_full);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    state_d     = state_q;
    tap_idx_d   = tap_idx_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    delay_d     = delay_q;
    gain_d      = gain_q;
    acc_d       = acc_q;
    rd_gain_d   = '0;
    rd_pend_d   = 1'b0;
    mix_out_d   = mix_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q || (in_valid && !in_ready);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_READ;
          tap_idx_d = '0;
          acc_d     = '0;
          delay_d   = delay;
          gain_d    = gain;
        end
      end
      S_READ: begin
        acc_d     = acc_sum;
        rd_pend_d = 1'b1;
        rd_gain_d = (tap_delay <= fill_q) ? tap_gain : '0;
        if (tap_idx_q == LAST_TAP) begin
          state_d = S_DRAIN;
        end else begin
          tap_idx_d = tap_idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        acc_d       = acc_sum;
        mix_out_d   = mix_sat;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values and simulation matches the synthesised hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tap_idx_q   <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      delay_q     <= '0;
      gain_q      <= '0;
      acc_q       <= '0;
      rd_gain_q   <= '0;
      rd_pend_q   <= 1'b0;
      mix_out_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_idx_q   <= tap_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      delay_q     <= delay_d;
      gain_q      <= gain_d;
      acc_q       <= acc_d;
      rd_gain_q   <= rd_gain_d;
      rd_pend_q   <= rd_pend_d;
      mix_out_q   <= mix_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the sample RAM is deliberately not reset; fill masking hides unwritten
  // entries, and leaving reset off lets the array map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_ptr_q] <= sample_in;
    end
    ram_rd_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_multitap_delay.sv
// Scoreboard bench for multitap_delay: a sample-history model predicts each mix,
// and a monitor compares it whenever out_valid pulses.
module tb_multitap_delay;

  localparam int A  = 9;
  localparam int D  = 8;
  localparam int NT = 4;
  localparam int G  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [D-1:0]      sample_in = '0;
  logic [NT*A-1:0]   delay = '0;
  logic [NT*G-1:0]   gain = '0;
  logic [D-1:0]      mix_out;
  logic              out_valid;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  int hist[$];     // every accepted sample since reset, oldest first
  int exp_q[$];    // expected mixes awaiting out_valid
  int exp_hold = 0;

  multitap_delay #(.A_WIDTH(A), .D_WIDTH(D), .NTAPS(NT), .G_WIDTH(G)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sample_in(sample_in), .delay(delay), .gain(gain),
    .mix_out(mix_out), .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected mix for the newest sample in hist, straight from the delay/gain rules.
  function automatic int model_mix(input logic [NT*A-1:0] d, input logic [NT*G-1:0] g);
    int n, fill, acc, di, gi, mix;
    n    = hist.size() - 1;
    fill = (n > (1 << A) - 1) ? (1 << A) - 1 : n;
    acc  = 0;
    for (int i = 0; i < NT; i++) begin
      di = int'(d[i*A +: A]);
      gi = int'(g[i*G +: G]);
      if (di <= fill) acc += hist[n - di] * gi;
    end
    mix = acc >> G;
    return (mix > (1 << D) - 1) ? (1 << D) - 1 : mix;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_hold = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_hold = exp_q.pop_front();
        check("mix_out", int'(mix_out), exp_hold);
      end
    end else begin
      check("mix_hold", int'(mix_out), exp_hold);
    end
  end

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Leaves in_valid high in the accept cycle (cycle 0); the caller drops it.
  task automatic accept_now(input logic [D-1:0] s, input logic [NT*A-1:0] d,
                            input logic [NT*G-1:0] g, input bit push);
    int budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    sample_in = s;
    delay     = d;
    gain      = g;
    in_valid  = 1'b1;
    if (push) begin
      hist.push_back(int'(s));
      exp_q.push_back(model_mix(d, g));
    end
  endtask

  task automatic send(input logic [D-1:0] s, input logic [NT*A-1:0] d, input logic [NT*G-1:0] g);
    accept_now(s, d, g, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    sample_in = D'($urandom);
    delay     = (NT*A)'({$urandom, $urandom});
    gain      = (NT*G)'($urandom);
  endtask

  task automatic wait_drained();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [NT*A-1:0] pack_d(input int d0, input int d1, input int d2, input int d3);
    return {A'(d3), A'(d2), A'(d1), A'(d0)};
  endfunction

  function automatic logic [NT*G-1:0] pack_g(input int g0, input int g1, input int g2, input int g3);
    return {G'(g3), G'(g2), G'(g1), G'(g0)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("in_ready_en0", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mix_out", int'(mix_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    en = 1'b1;
    #1;
    check("in_ready_en1", int'(in_ready), 1);

    // Cycle-exact handshake: sample 100, tap0 gain 8 -> 50
    accept_now(8'd100, pack_d(0, 1, 2, 3), pack_g(8, 0, 0, 0), 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      check($sformatf("in_ready_c%0d", k), int'(in_ready), (k == 7) ? 1 : 0);
      check($sformatf("out_valid_c%0d", k), int'(out_valid), (k == 6) ? 1 : 0);
    end
    wait_drained();

    // Fill masking: 200 then 10, tap1 delay 1 gain 15
    do_reset();
    send(8'd200, pack_d(0, 1, 0, 0), pack_g(0, 15, 0, 0));
    send(8'd10,  pack_d(0, 1, 0, 0), pack_g(0, 15, 0, 0));
    wait_drained();

    // Ramp with a 10-sample echo
    do_reset();
    for (int n = 0; n < 20; n++) send(D'(n), pack_d(0, 10, 0, 0), pack_g(8, 8, 0, 0));
    wait_drained();

    // Saturation
    send(8'd255, pack_d(0, 0, 0, 0), pack_g(15, 15, 15, 15));
    wait_drained();

    // Pointer wrap over 600 samples at the maximum delay
    do_reset();
    for (int n = 0; n < 601; n++) send(D'(n % 256), pack_d(511, 0, 0, 0), pack_g(15, 0, 0, 0));
    wait_drained();

    // Overrun with en low, then while busy in READ
    do_reset();
    en = 1'b0;
    in_valid = 1'b1;
    sample_in = 8'd33;
    @(negedge clk);
    in_valid = 1'b0;
    en = 1'b1;
    check("overrun_en_low", int'(overrun), 1);
    do_reset();
    send(8'd40, pack_d(0, 0, 0, 0), pack_g(8, 0, 0, 0));
    accept_now(8'd60, pack_d(0, 1, 0, 0), pack_g(8, 8, 0, 0), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_busy", int'(in_ready), 0);
    in_valid = 1'b1;
    sample_in = 8'd250;
    @(negedge clk);
    in_valid = 1'b0;
    check("overrun_busy", int'(overrun), 1);
    wait_drained();
    send(8'd80, pack_d(0, 1, 2, 0), pack_g(4, 4, 4, 0));
    wait_drained();
    check("overrun_sticky", int'(overrun), 1);

    // Reset during READ aborts the sample
    accept_now(8'd90, pack_d(0, 0, 0, 0), pack_g(15, 0, 0, 0), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_overrun", int'(overrun), 0);
    check("abort_out_valid", int'(out_valid), 0);
    repeat (10) @(negedge clk);
    send(8'd200, pack_d(0, 1, 0, 0), pack_g(0, 15, 0, 0));
    wait_drained();

    // Randomised traffic with occasional enable gaps
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [NT*A-1:0] d;
      logic [NT*G-1:0] g;
      for (int i = 0; i < NT; i++) begin
        d[i*A +: A] = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 12));
        g[i*G +: G] = G'($urandom);
      end
      send(D'($urandom), d, g);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        en = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        en = 1'b1;
      end
    end
    wait_drained();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
